// File: rtl/matrix_mem_if.sv
// Start/done memory handshake bundle between the control FSM (master) and the memory responder (slave).
interface matrix_mem_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned N_ELEM = 25
);
    logic                    start;
    logic                    wr;
    logic                    bulk;
    logic [ADDR_W-1:0]       address;
    logic [7:0]              data_in;
    logic [8*N_ELEM-1:0]     matrix_in;
    logic [7:0]              data_out;
    logic [8*N_ELEM-1:0]     matrix_out;
    logic                    done;
    logic                    busy;
    logic                    err;

    modport master (
        output start, wr, bulk, address, data_in, matrix_in,
        input  data_out, matrix_out, done, busy, err
    );

    modport slave (
        input  start, wr, bulk, address, data_in, matrix_in,
        output data_out, matrix_out, done, busy, err
    );
endinterface

// File: rtl/matrix_mem_responder.sv
// Byte-RAM responder for single-byte and 25-byte matrix reads/writes over a 4-phase start/done handshake.
// Optional MEM_ADDR_CHECK_EN: flag out-of-range requests on err and suppress their RAM access.
module matrix_mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned N_ELEM  = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    matrix_mem_if.slave   bus
);
    localparam int unsigned MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_MAX  = (N_ELEM > LATENCY) ? N_ELEM : LATENCY;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned LAT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t                state, state_nx;
    logic                  wr_q, bulk_q, err_q;
    logic [ADDR_W-1:0]     base_q;
    logic [7:0]            din_q;
    logic [8*N_ELEM-1:0]   min_q;
    logic [CNT_W-1:0]      cnt;
    logic [7:0]            mem [DEPTH];
    logic [31:0]           addr_sum;
    logic [MEM_AW-1:0]     addr;
    logic                  last_elem;
    logic                  access;
    logic                  err_req;

`ifdef MEM_ADDR_CHECK_EN
    assign err_req = (32'(bus.address) >= DEPTH) ||
                     (bus.bulk && (32'(bus.address) + N_ELEM - 1 >= DEPTH));
`else
    assign err_req = 1'b0;
`endif

    // Erroneous requests still walk through XFER so done keeps its normal latency.
    always_comb begin
        addr_sum  = 32'(base_q) + 32'(cnt);
        addr      = MEM_AW'(addr_sum % DEPTH);
        last_elem = bulk_q ? (cnt == CNT_W'(N_ELEM - 1)) : (cnt == '0);
        access    = (state == XFER) && !err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus.done = (state == DONE);
        bus.busy = (state != IDLE);
        bus.err  = err_q;
        case (state)
            IDLE: if (bus.start) state_nx = (LATENCY == 0) ? XFER : WAIT;
            WAIT: if (cnt == CNT_W'(LAT_LAST)) state_nx = XFER;
            XFER: if (last_elem) state_nx = DONE;
            DONE: if (!bus.start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q           <= 1'b0;
            bulk_q         <= 1'b0;
            err_q          <= 1'b0;
            base_q         <= '0;
            din_q          <= '0;
            min_q          <= '0;
            cnt            <= '0;
            bus.data_out   <= '0;
            bus.matrix_out <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    wr_q   <= bus.wr;
                    bulk_q <= bus.bulk;
                    base_q <= bus.address;
                    din_q  <= bus.data_in;
                    min_q  <= bus.matrix_in;
                    err_q  <= err_req;
                    cnt    <= '0;
                end
                WAIT: cnt <= (cnt == CNT_W'(LAT_LAST)) ? '0 : cnt + 1'b1;
                XFER: begin
                    if (!last_elem) cnt <= cnt + 1'b1;
                    if (access && !wr_q) begin
                        if (bulk_q) bus.matrix_out[8*cnt +: 8] <= mem[addr];
                        else        bus.data_out <= mem[addr];
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM contents survive reset; the async reset forces IDLE so no write follows it.
    always_ff @(posedge clk) begin
        if (access && wr_q)
            mem[addr] <= bulk_q ? min_q[8*cnt +: 8] : din_q;
    end
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed self-checking bench: default-latency responder plus a LATENCY=0 instance.
module tb_matrix_mem_responder;
    logic         clk;
    logic         rst_n;
    logic         start0, start1;
    logic         s_wr, s_bulk;
    logic [7:0]   s_addr, s_din;
    logic [199:0] s_min;
    int           errors;
    int           checks;

    matrix_mem_if #(.ADDR_W(8), .N_ELEM(25)) bus0 ();
    matrix_mem_if #(.ADDR_W(8), .N_ELEM(25)) bus1 ();

    assign bus0.start = start0;     assign bus1.start = start1;
    assign bus0.wr = s_wr;          assign bus1.wr = s_wr;
    assign bus0.bulk = s_bulk;      assign bus1.bulk = s_bulk;
    assign bus0.address = s_addr;   assign bus1.address = s_addr;
    assign bus0.data_in = s_din;    assign bus1.data_in = s_din;
    assign bus0.matrix_in = s_min;  assign bus1.matrix_in = s_min;

    matrix_mem_responder #(.ADDR_W(8), .DEPTH(256), .LATENCY(2), .N_ELEM(25)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    matrix_mem_responder #(.ADDR_W(8), .DEPTH(256), .LATENCY(0), .N_ELEM(25)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] pat(input logic [7:0] b);
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < 25; i++) m[8*i +: 8] = b + 8'(i);
        return m;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 0) ? bus0.done : bus1.done;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? bus0.busy : bus1.busy;
    endfunction

    // One request: exp_lat counts negedges from raising start until done is seen.
    task automatic run(input int which, input logic w, input logic b, input logic [7:0] a,
                       input logic [7:0] d, input logic [199:0] m, input int exp_lat,
                       input int hold, input string tag);
        int   cyc;
        logic dn;
        s_wr = w; s_bulk = b; s_addr = a; s_din = d; s_min = m;
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        cyc = 0;
        dn  = 1'b0;
        while (!dn && cyc < 200) begin
            @(negedge clk);
            cyc++;
            dn = get_done(which);
            if (cyc == 1) begin
                check({tag, " busy"}, 200'(get_busy(which)), 200'(1));
                s_addr = a + 8'h3; s_din = ~d; s_min = ~m;
            end
        end
        check({tag, " latency"}, 200'(cyc), 200'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold done"}, 200'(get_done(which)), 200'(1));
        end
        if (which == 0) start0 = 1'b0; else start1 = 1'b0;
        @(negedge clk);
        check({tag, " done clr"}, 200'(get_done(which)), 200'(0));
        check({tag, " idle"}, 200'(get_busy(which)), 200'(0));
    endtask

    initial begin
        logic [199:0] mix;
        errors = 0; checks = 0;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        s_wr = 1'b0; s_bulk = 1'b0; s_addr = '0; s_din = '0; s_min = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst done", 200'(bus0.done), 200'(0));
        check("rst busy", 200'(bus0.busy), 200'(0));
        check("rst err", 200'(bus0.err), 200'(0));
        check("rst data_out", 200'(bus0.data_out), 200'(0));
        check("rst matrix_out", bus0.matrix_out, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // single write then read
        run(0, 1'b1, 1'b0, 8'h10, 8'hA5, '0, 4, 0, "wr1");
        run(0, 1'b0, 1'b0, 8'h10, 8'h00, '0, 4, 0, "rd1");
        check("rd1 data", 200'(bus0.data_out), 200'(8'hA5));
        check("rd1 matrix kept", bus0.matrix_out, '0);

        // bulk write, single read inside it, bulk read back
        run(0, 1'b1, 1'b1, 8'h20, 8'h00, pat(8'h01), 28, 0, "bwr2");
        run(0, 1'b0, 1'b0, 8'h2C, 8'h00, '0, 4, 0, "rd2");
        check("rd2 data", 200'(bus0.data_out), 200'(8'h0D));
        run(0, 1'b0, 1'b1, 8'h20, 8'h00, '0, 28, 0, "brd2");
        check("brd2 matrix", bus0.matrix_out, pat(8'h01));
        check("brd2 data kept", 200'(bus0.data_out), 200'(8'h0D));

        // start held after done: one write only, scrambled inputs ignored
        run(0, 1'b1, 1'b0, 8'h43, 8'h11, '0, 4, 0, "pre3");
        run(0, 1'b1, 1'b0, 8'h40, 8'h33, '0, 4, 5, "hold3");
        run(0, 1'b0, 1'b0, 8'h40, 8'h00, '0, 4, 0, "rd3a");
        check("rd3a data", 200'(bus0.data_out), 200'(8'h33));
        run(0, 1'b0, 1'b0, 8'h43, 8'h00, '0, 4, 0, "rd3b");
        check("rd3b data", 200'(bus0.data_out), 200'(8'h11));

        // wrap-around bulk at 0xF0
`ifdef MEM_ADDR_CHECK_EN
        run(0, 1'b1, 1'b1, 8'hF0, 8'h00, pat(8'h80), 28, 0, "bwr4");
        check("bwr4 err", 200'(bus0.err), 200'(1));
        run(0, 1'b0, 1'b1, 8'hF0, 8'h00, '0, 28, 0, "brd4");
        check("brd4 err", 200'(bus0.err), 200'(1));
        check("brd4 matrix kept", bus0.matrix_out, pat(8'h01));
        run(0, 1'b0, 1'b0, 8'h10, 8'h00, '0, 4, 0, "rd4");
        check("rd4 err clr", 200'(bus0.err), 200'(0));
        check("rd4 data", 200'(bus0.data_out), 200'(8'hA5));
`else
        run(0, 1'b1, 1'b1, 8'hF0, 8'h00, pat(8'h80), 28, 0, "bwr4");
        check("bwr4 err", 200'(bus0.err), 200'(0));
        run(0, 1'b0, 1'b1, 8'hF0, 8'h00, '0, 28, 0, "brd4");
        check("brd4 matrix", bus0.matrix_out, pat(8'h80));
        run(0, 1'b0, 1'b0, 8'h05, 8'h00, '0, 4, 0, "rd4a");
        check("rd4a data", 200'(bus0.data_out), 200'(8'h95));
        run(0, 1'b0, 1'b0, 8'h08, 8'h00, '0, 4, 0, "rd4b");
        check("rd4b data", 200'(bus0.data_out), 200'(8'h98));
`endif

        // reset during element 10 of a bulk write
        run(0, 1'b1, 1'b1, 8'h60, 8'h00, pat(8'hC0), 28, 0, "pre5");
        s_wr = 1'b1; s_bulk = 1'b1; s_addr = 8'h60; s_min = pat(8'h10);
        start0 = 1'b1;
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst5 done", 200'(bus0.done), 200'(0));
        check("rst5 busy", 200'(bus0.busy), 200'(0));
        check("rst5 matrix", bus0.matrix_out, '0);
        check("rst5 data", 200'(bus0.data_out), 200'(0));
        @(negedge clk);
        start0 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1'b0, 1'b1, 8'h60, 8'h00, '0, 28, 0, "brd5");
        mix = '0;
        for (int i = 0; i < 25; i++) mix[8*i +: 8] = (i < 10) ? 8'(8'h10 + i) : 8'(8'hC0 + i);
        check("brd5 matrix", bus0.matrix_out, mix);

        // zero-latency instance
        run(1, 1'b1, 1'b0, 8'h10, 8'h5A, '0, 2, 0, "l0wr");
        run(1, 1'b0, 1'b0, 8'h10, 8'h00, '0, 2, 0, "l0rd");
        check("l0rd data", 200'(bus1.data_out), 200'(8'h5A));
        run(1, 1'b1, 1'b1, 8'h30, 8'h00, pat(8'h40), 26, 0, "l0bwr");
        run(1, 1'b0, 1'b1, 8'h30, 8'h00, '0, 26, 0, "l0brd");
        check("l0brd matrix", bus1.matrix_out, pat(8'h40));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
